// File: rtl/optimsoc_config_pkt.sv
// Configuration report packet generator: on request, emits a 9-flit NoC packet
// (header + 8 payload words) describing the system configuration.

package optimsoc_config;
   typedef struct packed {
      logic [31:0] NUMTILES;
      logic [31:0] NUMCTS;
      logic [31:0] CORES_PER_TILE;
      logic [31:0] GMEM_SIZE;
      logic [31:0] GMEM_TILE;
      logic [31:0] LMEM_SIZE;
      logic        USE_DEBUG;
      logic        NOC_ENABLE_VCHANNELS;
      logic        ENABLE_BOOTROM;
      logic        ENABLE_DM;
      logic        ENABLE_PGAS;
      logic        NA_ENABLE_MPSIMPLE;
      logic        NA_ENABLE_DMA;
      logic [31:0] DEBUG_NUM_MODS;
      logic [31:0] TOTAL_NUM_CORES;
   } config_t;
endpackage

// state | meaning
// IDLE  | waiting for a request, req_ready high
// HDR   | header flit presented
// PAY   | payload word idx presented, idx==7 is the last flit
module optimsoc_config_pkt #(
   parameter optimsoc_config::config_t CONFIG = 'x,
   parameter int                       TILEID = 0,
   parameter logic [2:0]               CLASS  = 3'h4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_dest,
   output logic [31:0] out_flit,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic [7:0]  pkt_count
);

   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

   localparam logic [4:0] TILE5 = TILEID[4:0];

   state_t      state, state_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [4:0]  dest;
   logic [31:0] payload;
   logic        pkt_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= 3'd0;
         dest      <= 5'd0;
         pkt_count <= 8'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (state == IDLE && req_valid)
            dest <= req_dest;
         if (pkt_done)
            pkt_count <= pkt_count + 8'd1;
      end
   end

   always_comb begin
      payload = 32'h0;
      case (idx)
         3'd0: payload = {CONFIG.NUMCTS[15:0], CONFIG.NUMTILES[15:0]};
         3'd1: payload = CONFIG.CORES_PER_TILE;
         3'd2: payload = CONFIG.GMEM_SIZE;
         3'd3: payload = CONFIG.GMEM_TILE;
         3'd4: payload = CONFIG.LMEM_SIZE;
         3'd5: payload = {25'h0, CONFIG.NA_ENABLE_DMA, CONFIG.NA_ENABLE_MPSIMPLE,
                          CONFIG.ENABLE_PGAS, CONFIG.ENABLE_DM, CONFIG.ENABLE_BOOTROM,
                          CONFIG.NOC_ENABLE_VCHANNELS, CONFIG.USE_DEBUG};
         3'd6: payload = CONFIG.DEBUG_NUM_MODS;
         3'd7: payload = CONFIG.TOTAL_NUM_CORES;
         default: payload = 32'h0;
      endcase
   end

   // Outputs depend only on registered state so reset clears them at once.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      req_ready = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_flit  = 32'h0;
      pkt_done  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = HDR;
         end
         HDR: begin
            out_valid = 1'b1;
            out_flit  = {dest, CLASS, TILE5, 19'h0};
            if (out_ready) begin
               state_nxt = PAY;
               idx_nxt   = 3'd0;
            end
         end
         PAY: begin
            out_valid = 1'b1;
            out_flit  = payload;
            out_last  = (idx == 3'd7);
            if (out_ready) begin
               idx_nxt = idx + 3'd1;
               if (idx == 3'd7) begin
                  state_nxt = IDLE;
                  pkt_done  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_optimsoc_config_pkt.sv
// Directed testbench for optimsoc_config_pkt: packet contents, stalls,
// back-to-back requests, mid-packet reset and packet counter wrap.

module tb_optimsoc_config_pkt;

   localparam optimsoc_config::config_t TB_CFG = '{
      NUMTILES:             32'h0001_0004,
      NUMCTS:               32'h0000_0004,
      CORES_PER_TILE:       32'd1,
      GMEM_SIZE:            32'h1000_0000,
      GMEM_TILE:            32'd3,
      LMEM_SIZE:            32'h0000_8000,
      USE_DEBUG:            1'b1,
      NOC_ENABLE_VCHANNELS: 1'b0,
      ENABLE_BOOTROM:       1'b0,
      ENABLE_DM:            1'b1,
      ENABLE_PGAS:          1'b0,
      NA_ENABLE_MPSIMPLE:   1'b0,
      NA_ENABLE_DMA:        1'b0,
      DEBUG_NUM_MODS:       32'd5,
      TOTAL_NUM_CORES:      32'd4
   };

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_dest = 5'd0;
   logic [31:0] out_flit;
   logic        out_last;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic [7:0]  pkt_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] pay [0:7];
   logic [31:0] got [0:8];
   logic        gl  [0:8];
   int          nf;
   int          first_valid;
   int          last_cyc;

   optimsoc_config_pkt #(.CONFIG(TB_CFG), .TILEID(1), .CLASS(3'h4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_dest(req_dest), .out_flit(out_flit), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   // Collects one packet; caller has already raised req_valid at a negedge.
   task automatic capture(input bit rnd, input bit keep_req, input int chg_dest, input int budget);
      int          cyc;
      bit          stalled;
      logic [31:0] held;
      logic        held_last;
      nf = 0; cyc = 0; first_valid = -1; stalled = 0; last_cyc = 0;
      while (nf < 9 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (!keep_req) req_valid = 1'b0;
         if (chg_dest >= 0 && cyc == 4) req_dest = chg_dest[4:0];
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_flit !== held || out_last !== held_last) begin
               errors++;
               $display("FAIL stall_hold: valid=%b flit=%h last=%b, required valid=1 flit=%h last=%b",
                        out_valid, out_flit, out_last, held, held_last);
            end
         end
         if (out_valid === 1'b1) begin
            if (first_valid < 0) first_valid = cyc;
            checks++;
            if (busy !== 1'b1 || req_ready !== 1'b0) begin
               errors++;
               $display("FAIL busy_in_pkt: busy=%b req_ready=%b, required 1/0", busy, req_ready);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) begin
               got[nf] = out_flit; gl[nf] = out_last; nf++; stalled = 0; last_cyc = cyc;
            end else begin
               stalled = 1; held = out_flit; held_last = out_last;
            end
         end else begin
            stalled = 0;
         end
      end
      checks++;
      if (nf != 9) begin
         errors++;
         $display("FAIL pkt_timeout: got %0d flits, required 9", nf);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_flit !== 32'h0 || busy !== 1'b0 ||
          req_ready !== 1'b1 || pkt_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b last=%b flit=%h busy=%b ready=%b cnt=%0d, required 0 0 0 0 1 0",
                  out_valid, out_last, out_flit, busy, req_ready, pkt_count);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      @(negedge clk);
      req_valid = 1'b1; req_dest = 5'd3;
      capture(0, 0, -1, 40);
      checks++;
      if (first_valid != 1 || last_cyc != 9) begin
         errors++;
         $display("FAIL basic_timing: first_valid=%0d last=%0d, required 1 and 9", first_valid, last_cyc);
      end
      checks++;
      if (got[0] !== 32'h1C08_0000) begin
         errors++;
         $display("FAIL basic_header: got %h, required 1c080000", got[0]);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got[i+1] !== pay[i]) begin
            errors++;
            $display("FAIL basic_w%0d: got %h, required %h", i, got[i+1], pay[i]);
         end
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (gl[i] !== (i == 8)) begin
            errors++;
            $display("FAIL basic_last%0d: got %b, required %b", i, gl[i], (i == 8));
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_flit !== 32'h0 || req_ready !== 1'b1 || busy !== 1'b0 ||
          pkt_count !== 8'd1) begin
         errors++;
         $display("FAIL basic_after: valid=%b flit=%h ready=%b busy=%b cnt=%0d, required 0 0 1 0 1",
                  out_valid, out_flit, req_ready, busy, pkt_count);
      end
   endtask

   task automatic test_stall();
      req_valid = 1'b1; req_dest = 5'd3;
      capture(1, 0, -1, 300);
      checks++;
      if (got[0] !== 32'h1C08_0000) begin
         errors++;
         $display("FAIL stall_header: got %h, required 1c080000", got[0]);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got[i+1] !== pay[i] || gl[i+1] !== (i == 7)) begin
            errors++;
            $display("FAIL stall_w%0d: got %h last=%b, required %h last=%b",
                     i, got[i+1], gl[i+1], pay[i], (i == 7));
         end
      end
      @(negedge clk);
      checks++;
      if (pkt_count !== 8'd2) begin
         errors++;
         $display("FAIL stall_count: got %0d, required 2", pkt_count);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      req_valid = 1'b1; req_dest = 5'd7;
      capture(0, 1, 9, 40);
      checks++;
      if (got[0] !== 32'h3C08_0000) begin
         errors++;
         $display("FAIL b2b_header1: got %h, required 3c080000", got[0]);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_flit !== 32'h0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: valid=%b flit=%h ready=%b, required 0 0 1", out_valid, out_flit, req_ready);
      end
      capture(0, 1, -1, 40);
      req_valid = 1'b0;
      checks++;
      if (first_valid != 1 || got[0] !== 32'h4C08_0000 || got[8] !== pay[7]) begin
         errors++;
         $display("FAIL b2b_pkt2: first_valid=%0d hdr=%h w7=%h, required 1 4c080000 %h",
                  first_valid, got[0], got[8], pay[7]);
      end
      @(negedge clk);
      checks++;
      if (pkt_count !== 8'd4 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_count: cnt=%0d ready=%b, required 4 1", pkt_count, req_ready);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      req_valid = 1'b1; req_dest = 5'd3;
      repeat (6) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      checks++;
      if (out_valid !== 1'b1 || out_flit !== pay[4]) begin
         errors++;
         $display("FAIL mid_idx4: valid=%b flit=%h, required 1 %h", out_valid, out_flit, pay[4]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_flit !== 32'h0 || out_last !== 1'b0 || busy !== 1'b0 ||
          req_ready !== 1'b1 || pkt_count !== 8'd0) begin
         errors++;
         $display("FAIL mid_async: valid=%b flit=%h last=%b busy=%b ready=%b cnt=%0d, required 0 0 0 0 1 0",
                  out_valid, out_flit, out_last, busy, req_ready, pkt_count);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_held: valid=%b busy=%b, required 0 0", out_valid, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_dest = 5'd3;
      capture(0, 0, -1, 40);
      checks++;
      if (got[0] !== 32'h1C08_0000 || got[5] !== pay[4] || got[8] !== pay[7] || gl[8] !== 1'b1) begin
         errors++;
         $display("FAIL mid_recover: hdr=%h w4=%h w7=%h last=%b, required 1c080000 %h %h 1",
                  got[0], got[5], got[8], gl[8], pay[4], pay[7]);
      end
   endtask

   task automatic test_wrap();
      // pkt_count is 1 after the recovery packet.
      for (int k = 2; k <= 256; k++) begin
         @(negedge clk);
         if (k == 256) begin
            checks++;
            if (pkt_count !== 8'd255) begin
               errors++;
               $display("FAIL wrap_255: got %0d, required 255", pkt_count);
            end
         end
         req_valid = 1'b1; req_dest = 5'd2;
         capture(0, 0, -1, 40);
      end
      @(negedge clk);
      checks++;
      if (pkt_count !== 8'd0) begin
         errors++;
         $display("FAIL wrap_0: got %0d, required 0", pkt_count);
      end
   endtask

   initial begin
      pay[0] = 32'h0004_0004; pay[1] = 32'd1;         pay[2] = 32'h1000_0000; pay[3] = 32'd3;
      pay[4] = 32'h0000_8000; pay[5] = 32'h0000_0009; pay[6] = 32'd5;         pay[7] = 32'd4;
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
